// File: rtl/misr_response_compactor.sv
`default_nettype none
// ============================================================================
// Module   : misr_response_compactor
// Purpose  : Compacts one CUT response per accepted pattern into a Galois MISR
//            and grades the final signature against GOLDEN.
// Options  : MISR_XMASK_EN adds resp_xmask to zero unknown response bits.
// Revision : 1.0
// ============================================================================
module misr_response_compactor #(
  parameter int               RESP_W   = 2,
  parameter int               SIG_W    = 8,
  parameter logic [SIG_W-1:0] POLY     = 8'h1D,
  parameter logic [SIG_W-1:0] SEED     = 8'h00,
  parameter int               NUM_PATS = 4,
  parameter logic [SIG_W-1:0] GOLDEN   = 8'h0D,
  localparam int              CNT_W    = $clog2(NUM_PATS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp,
`ifdef MISR_XMASK_EN
  input  logic [RESP_W-1:0] resp_xmask,
`endif
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  pat_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATS - 1);

  state_t            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pass_q, pass_d;

  logic [RESP_W-1:0] w_resp_eff;
  logic [SIG_W-1:0]  w_misr_next;
  logic              w_accept;

`ifdef MISR_XMASK_EN
  assign w_resp_eff = resp & ~resp_xmask;
`else
  assign w_resp_eff = resp;
`endif

  // Galois step: shift left, fold the dropped MSB back through POLY, inject response
  assign w_misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? POLY : '0)
                     ^ SIG_W'(w_resp_eff);

  assign w_accept = (state_q == ST_RUN) && resp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          sig_d   = SEED;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          sig_d = w_misr_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        pass_d  = (sig_q == GOLDEN);
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign resp_ready = (state_q == ST_RUN);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign pat_count  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_misr_response_compactor.sv
`default_nettype none
// ============================================================================
// Module   : tb_misr_response_compactor
// Purpose  : Self-checking bench for misr_response_compactor (default and
//            NUM_PATS=1/SEED=80 feedback instances).
// Revision : 1.0
// ============================================================================
module tb_misr_response_compactor;

  localparam int POLY     = 'h1D;
  localparam int SEED     = 'h00;
  localparam int NUM_PATS = 4;
  localparam int GOLDEN   = 'h0D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       resp_valid = 1'b0;
  logic [1:0] resp = 2'b00;
  logic [1:0] resp_xmask = 2'b00;
  logic       resp_ready, busy, done, pass;
  logic [7:0] signature;
  logic [2:0] pat_count;

  logic       fb_start = 1'b0;
  logic       fb_valid = 1'b0;
  logic [1:0] fb_resp = 2'b00;
  logic [1:0] fb_mask = 2'b00;
  logic       fb_ready, fb_busy, fb_done, fb_pass;
  logic [7:0] fb_sig;
  logic [0:0] fb_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  misr_response_compactor u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .resp_valid (resp_valid),
    .resp       (resp),
`ifdef MISR_XMASK_EN
    .resp_xmask (resp_xmask),
`endif
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .pat_count  (pat_count)
  );

  misr_response_compactor #(
    .SEED     (8'h80),
    .NUM_PATS (1),
    .GOLDEN   (8'h1D)
  ) u_fb (
    .clk        (clk),
    .rst        (rst),
    .start      (fb_start),
    .resp_valid (fb_valid),
    .resp       (fb_resp),
`ifdef MISR_XMASK_EN
    .resp_xmask (fb_mask),
`endif
    .resp_ready (fb_ready),
    .busy       (fb_busy),
    .done       (fb_done),
    .pass       (fb_pass),
    .signature  (fb_sig),
    .pat_count  (fb_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signature arithmetic: multiply by x modulo the feedback polynomial, add response
  function automatic int step(input int s, input int r);
    int t;
    t = s * 2;
    if (t >= 256) t = (t - 256) ^ POLY;
    return t ^ r;
  endfunction

  function automatic int eff_resp(input logic [1:0] r, input logic [1:0] m);
`ifdef MISR_XMASK_EN
    return int'(r & ~m);
`else
    return int'(r) + 0 * int'(m);
`endif
  endfunction

  // Reference model: run/check/done flags plus expected signature and count
  bit m_run, m_chk, m_done, m_pass;
  int m_sig, m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b0; m_chk <= 1'b0; m_done <= 1'b0; m_pass <= 1'b0;
      m_sig <= SEED; m_cnt <= 0;
    end else if (m_chk) begin
      m_pass <= (m_sig == GOLDEN);
      m_chk  <= 1'b0;
      m_done <= 1'b1;
    end else if (m_run) begin
      if (resp_valid) begin
        m_sig <= step(m_sig, eff_resp(resp, resp_xmask));
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == NUM_PATS) begin
          m_run <= 1'b0;
          m_chk <= 1'b1;
        end
      end
    end else if (start) begin
      m_run <= 1'b1; m_done <= 1'b0; m_pass <= 1'b0;
      m_sig <= SEED; m_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    chk("ready", int'(resp_ready), int'(m_run));
    chk("busy", int'(busy), int'(m_run | m_chk));
    chk("done", int'(done), int'(m_done));
    chk("pass", int'(pass), int'(m_pass));
    chk("sig", int'(signature), m_sig);
    chk("cnt", int'(pat_count), m_cnt);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] r, input logic [1:0] m);
    resp_valid = 1'b1;
    resp       = r;
    resp_xmask = m;
    cyc();
    resp_valid = 1'b0;
    resp_xmask = 2'b00;
  endtask

  initial begin
    logic [1:0] good [4];
    logic [7:0] good_sig [4];
    good     = '{2'd0, 2'd2, 2'd2, 2'd1};
    good_sig = '{8'h00, 8'h02, 8'h06, 8'h0D};

    cyc(); cyc();
    rst = 1'b0;
    chk("rst_sig", int'(signature), 'h00);
    chk("rst_cnt", int'(pat_count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("fb_rst_sig", int'(fb_sig), 'h80);

    // Feedback path: SEED=80, single zero response
    fb_start = 1'b1; cyc(); fb_start = 1'b0;
    fb_valid = 1'b1; fb_resp = 2'd0; cyc(); fb_valid = 1'b0;
    chk("fb_sig", int'(fb_sig), 'h1D);
    chk("fb_busy", int'(fb_busy), 1);
    cyc();
    chk("fb_done", int'(fb_done), 1);
    chk("fb_pass", int'(fb_pass), 1);
    chk("fb_cnt", int'(fb_cnt), 1);

    // start together with resp_valid in IDLE: only start counts
    resp_valid = 1'b1; resp = 2'd3;
    do_start();
    chk("start_sig", int'(signature), 'h00);
    chk("start_cnt", int'(pat_count), 0);
    for (int i = 0; i < 4; i++) begin
      send(good[i], 2'b00);
      chk("ff_sig", int'(signature), int'(good_sig[i]));
    end
    chk("ff_check_busy", int'(busy), 1);
    chk("ff_check_done", int'(done), 0);
    cyc();
    chk("ff_done", int'(done), 1);
    chk("ff_pass", int'(pass), 1);
    chk("ff_cnt", int'(pat_count), 4);

    // resp_valid while DONE is ignored
    send(2'd3, 2'b00);
    chk("done_hold_sig", int'(signature), 'h0D);

    // Stuck-at c=0
    do_start();
    send(2'd0, 2'b00); send(2'd2, 2'b00); send(2'd2, 2'b00); send(2'd0, 2'b00);
    cyc();
    chk("sa0_sig", int'(signature), 'h0C);
    chk("sa0_pass", int'(pass), 0);
    chk("sa0_done", int'(done), 1);

    // Gapped responses with a mid-run start
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(good[i], 2'b00);
      repeat ($urandom_range(0, 3)) cyc();
      if (i == 1) begin
        do_start();
        chk("midstart_cnt", int'(pat_count), 2);
        chk("midstart_sig", int'(signature), 'h02);
      end
    end
    repeat (2) cyc();
    chk("gap_sig", int'(signature), 'h0D);
    chk("gap_pass", int'(pass), 1);

    // Reset mid-run
    do_start();
    send(2'd0, 2'b00); send(2'd2, 2'b00);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mrst_sig", int'(signature), 'h00);
    chk("mrst_cnt", int'(pat_count), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_busy", int'(busy), 0);

`ifdef MISR_XMASK_EN
    do_start();
    send(2'd0, 2'b00); send(2'd2, 2'b00); send(2'd2, 2'b00); send(2'd1, 2'b01);
    cyc();
    chk("xmask_sig", int'(signature), 'h0C);
    chk("xmask_pass", int'(pass), 0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      start      = ($urandom_range(0, 9) == 0);
      resp_valid = ($urandom_range(0, 2) != 0);
      resp       = 2'($urandom);
      resp_xmask = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      rst        = ($urandom_range(0, 80) == 0);
      cyc();
    end
    start = 1'b0; resp_valid = 1'b0; rst = 1'b0;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
